// File: rtl/ef_smsdac_dec_mon.sv
// Receive-side decoder/monitor for the segmented 3-level mismatch-shaping DAC bus.
// Decodes weighted element codes, integrates per-element usage, checks boundedness, block-sums output.
module ef_smsdac_dec_mon #(
  parameter int DEC_LOG2 = 4,
  parameter int BOUND    = 2,
  parameter int INT_W    = 6,
  parameter int SETTLE_N = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       en,
  input  logic                       clear,
  input  logic [1:0]                 code_3,
  input  logic [1:0]                 code_2,
  input  logic [1:0]                 code_1,
  input  logic [1:0]                 code_0,
  output logic signed [4:0]          y_sum,
  output logic                       y_vld,
  output logic signed [4+DEC_LOG2:0] y_avg,
  output logic                       y_avg_vld,
  output logic [4*INT_W-1:0]         elem_int,
  output logic [3:0]                 viol,
  output logic [3:0]                 ill,
  output logic                       armed
);

  localparam int AW = 5 + DEC_LOG2;
  localparam logic signed [INT_W-1:0] IMAX = INT_W'((2 ** (INT_W - 1)) - 1);
  localparam logic signed [INT_W-1:0] BND  = INT_W'(BOUND);
  localparam logic signed [INT_W-1:0] ONE  = INT_W'(1);
  localparam logic [3:0]              SETTLE_LAST = 4'(SETTLE_N - 1);

  // Valid/ready: there is no back-pressure. A sample is transferred on every rising
  // edge where en=1 and clear=0; each downstream strobe marks exactly one sample.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;

  logic            s1_vld_q;
  logic [3:0][1:0] s1_code_q;

  logic signed [4:0]       y_sum_q, y_sum_d;
  logic                    y_vld_q, y_vld_d;
  logic signed [INT_W-1:0] int_q [4];
  logic signed [INT_W-1:0] int_d [4];
  logic [3:0]              viol_q, viol_d;
  logic [3:0]              ill_q, ill_d;

  logic signed [AW-1:0]    acc_q, acc_d;
  logic [DEC_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [AW-1:0]    y_avg_q, y_avg_d;
  logic                    y_avg_vld_q, y_avg_vld_d;

  logic signed [1:0] e_val [4];
  logic [3:0]        illegal;
  logic [3:0]        over;
  logic signed [4:0] sum_dec;
  logic              chk_en;
  logic signed [AW-1:0] y_sum_ext;

  // Stage 1: capture codes and qualifier; clear flushes the in-flight sample.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_vld_q  <= 1'b0;
      s1_code_q <= '0;
    end else begin
      s1_vld_q <= en & ~clear;
      if (en) begin
        s1_code_q <= {code_3, code_2, code_1, code_0};
      end
    end
  end

  // Element decode and saturating integrator update.
  always_comb begin
    sum_dec = '0;
    illegal = '0;
    over    = '0;
    for (int k = 0; k < 4; k++) begin
      case (s1_code_q[k])
        2'b10:   e_val[k] = 2'sb01;
        2'b01:   e_val[k] = 2'sb11;
        default: e_val[k] = 2'sb00;
      endcase
      illegal[k] = (s1_code_q[k] == 2'b11);
      sum_dec    = sum_dec + (5'(e_val[k]) <<< k);

      int_d[k] = int_q[k];
      if (e_val[k] == 2'sb01 && int_q[k] != IMAX) begin
        int_d[k] = int_q[k] + ONE;
      end else if (e_val[k] == 2'sb11 && int_q[k] != -IMAX) begin
        int_d[k] = int_q[k] - ONE;
      end
      over[k] = (int_d[k] > BND) || (int_d[k] < -BND);
    end
  end

  // The sample that completes settling is processed while still in SETTLE, so it is unchecked.
  assign chk_en = s1_vld_q && (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    if (clear) begin
      state_d      = S_IDLE;
      settle_cnt_d = '0;
    end else if (s1_vld_q) begin
      case (state_q)
        S_IDLE: begin
          settle_cnt_d = 4'd1;
          state_d      = (SETTLE_N <= 1) ? S_RUN : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q >= SETTLE_LAST) begin
            state_d = S_RUN;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    y_sum_d = y_sum_q;
    y_vld_d = 1'b0;
    viol_d  = viol_q;
    ill_d   = ill_q;
    if (clear) begin
      viol_d = '0;
      ill_d  = '0;
    end else if (s1_vld_q) begin
      y_sum_d = sum_dec;
      y_vld_d = 1'b1;
      ill_d   = ill_q | illegal;
      if (chk_en) begin
        viol_d = viol_q | over;
      end
    end
  end

  // Decimator consumes the registered stage-2 output, so y_avg lands one cycle after the last y_vld.
  assign y_sum_ext = AW'(y_sum_q);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_avg_d     = y_avg_q;
    y_avg_vld_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (y_vld_q) begin
      if (cnt_q == {DEC_LOG2{1'b1}}) begin
        y_avg_d     = acc_q + y_sum_ext;
        y_avg_vld_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_q + y_sum_ext;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      y_sum_q      <= '0;
      y_vld_q      <= 1'b0;
      viol_q       <= '0;
      ill_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      y_avg_q      <= '0;
      y_avg_vld_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        int_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      y_sum_q      <= y_sum_d;
      y_vld_q      <= y_vld_d;
      viol_q       <= viol_d;
      ill_q        <= ill_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      y_avg_q      <= y_avg_d;
      y_avg_vld_q  <= y_avg_vld_d;
      for (int k = 0; k < 4; k++) begin
        if (clear) begin
          int_q[k] <= '0;
        end else if (s1_vld_q) begin
          int_q[k] <= int_d[k];
        end
      end
    end
  end

  always_comb begin
    elem_int = '0;
    for (int k = 0; k < 4; k++) begin
      elem_int[k*INT_W +: INT_W] = int_q[k];
    end
  end

  assign y_sum     = y_sum_q;
  assign y_vld     = y_vld_q;
  assign y_avg     = y_avg_q;
  assign y_avg_vld = y_avg_vld_q;
  assign viol      = viol_q;
  assign ill       = ill_q;
  assign armed     = (state_q == S_RUN);

endmodule

// File: tb/tb_ef_smsdac_dec_mon.sv
// Bench for ef_smsdac_dec_mon: directed scenarios plus random traffic against an
// integer-arithmetic reference model of the decoder, integrators, settle gate and block sum.
module tb_ef_smsdac_dec_mon;

  localparam int DEC_LOG2 = 4;
  localparam int BOUND    = 2;
  localparam int INT_W    = 6;
  localparam int SETTLE_N = 4;
  localparam int BLK      = 1 << DEC_LOG2;
  localparam int IMAX     = (1 << (INT_W - 1)) - 1;

  logic                       clk;
  logic                       rst_b;
  logic                       en;
  logic                       clear;
  logic [1:0]                 code_v [4];
  logic signed [4:0]          y_sum;
  logic                       y_vld;
  logic signed [4+DEC_LOG2:0] y_avg;
  logic                       y_avg_vld;
  logic [4*INT_W-1:0]         elem_int;
  logic [3:0]                 viol;
  logic [3:0]                 ill;
  logic                       armed;

  int n_cmp = 0;
  int n_mis = 0;

  ef_smsdac_dec_mon #(
    .DEC_LOG2(DEC_LOG2),
    .BOUND(BOUND),
    .INT_W(INT_W),
    .SETTLE_N(SETTLE_N)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .en(en),
    .clear(clear),
    .code_3(code_v[3]),
    .code_2(code_v[2]),
    .code_1(code_v[1]),
    .code_0(code_v[0]),
    .y_sum(y_sum),
    .y_vld(y_vld),
    .y_avg(y_avg),
    .y_avg_vld(y_avg_vld),
    .elem_int(elem_int),
    .viol(viol),
    .ill(ill),
    .armed(armed)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_int [4];
  bit   m_viol [4];
  bit   m_ill [4];
  int   m_nval;           // valid samples seen since clear/reset (saturates at SETTLE_N)
  int   m_blk [$];        // samples of the current decimation block
  int   m_avg;
  bit   m_avgv;
  int   m_ysum;
  bit   m_yv;
  bit   m_p1;
  logic [1:0] m_pc [4];

  function automatic int elem_of(input logic [1:0] c);
    if (c == 2'b10) return 1;
    if (c == 2'b01) return -1;
    return 0;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_int[k] = 0; m_viol[k] = 0; m_ill[k] = 0; m_pc[k] = 2'b00;
    end
    m_nval = 0; m_blk.delete(); m_avg = 0; m_avgv = 0;
    m_ysum = 0; m_yv = 0; m_p1 = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int s;
    int e;
    if (clear) begin
      for (int k = 0; k < 4; k++) begin
        m_int[k] = 0; m_viol[k] = 0; m_ill[k] = 0;
      end
      m_nval = 0; m_blk.delete(); m_avgv = 0; m_yv = 0; m_p1 = 0;
      return;
    end
    m_avgv = 0;
    if (m_yv) begin
      m_blk.push_back(m_ysum);
      if (m_blk.size() == BLK) begin
        m_avg = 0;
        foreach (m_blk[i]) m_avg += m_blk[i];
        m_avgv = 1;
        m_blk.delete();
      end
    end
    if (m_p1) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        e = elem_of(m_pc[k]);
        if (m_pc[k] == 2'b11) m_ill[k] = 1;
        s += e * (1 << k);
        m_int[k] += e;
        if (m_int[k] > IMAX) m_int[k] = IMAX;
        if (m_int[k] < -IMAX) m_int[k] = -IMAX;
        if (m_nval >= SETTLE_N && iabs(m_int[k]) > BOUND) m_viol[k] = 1;
      end
      m_ysum = s;
      m_yv   = 1;
      if (m_nval < SETTLE_N) m_nval++;
    end else begin
      m_yv = 0;
    end
    m_p1 = en;
    for (int k = 0; k < 4; k++) m_pc[k] = code_v[k];
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bits4(input bit b [4]);
    return (b[3] << 3) | (b[2] << 2) | (b[1] << 1) | b[0];
  endfunction

  task automatic compare_all();
    check("y_sum", $signed(y_sum), m_ysum);
    check("y_vld", {31'd0, y_vld}, int'(m_yv));
    check("y_avg", $signed(y_avg), m_avg);
    check("y_avg_vld", {31'd0, y_avg_vld}, int'(m_avgv));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("int%0d", k), $signed(elem_int[k*INT_W +: INT_W]), m_int[k]);
    end
    check("viol", {28'd0, viol}, bits4(m_viol));
    check("ill", {28'd0, ill}, bits4(m_ill));
    check("armed", {31'd0, armed}, int'(m_nval >= SETTLE_N));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic apply(input logic [1:0] c3, input logic [1:0] c2,
                       input logic [1:0] c1, input logic [1:0] c0);
    code_v[3] = c3; code_v[2] = c2; code_v[1] = c1; code_v[0] = c0;
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_clear();
    en = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_b = 1'b0;
    #1 model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #3 rst_b = 1'b1;
  endtask

  function automatic int elem_field(input int k);
    return int'($signed(elem_int[k*INT_W +: INT_W]));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_b = 1'b0; en = 1'b0; clear = 1'b0;
    for (int k = 0; k < 4; k++) code_v[k] = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    #2 rst_b = 1'b1;

    // reset and idle
    idle(20);
    check("idle_armed", {31'd0, armed}, 0);

    // decode {10,01,00,10} -> +5
    apply(2'b10, 2'b01, 2'b00, 2'b10);
    idle(1);
    check("dec_y_sum", $signed(y_sum), 5);
    check("dec_y_vld", {31'd0, y_vld}, 1);
    check("dec_int3", elem_field(3), 1);
    check("dec_int2", elem_field(2), -1);
    idle(2);
    check("dec_vld_pulse", {31'd0, y_vld}, 0);

    // illegal code on element 2
    do_clear();
    apply(2'b00, 2'b11, 2'b00, 2'b00);
    idle(1);
    check("ill_y_sum", $signed(y_sum), 0);
    check("ill_flag", {28'd0, ill}, 4);
    check("ill_viol", {28'd0, viol}, 0);

    // settle / arm, then violation and stickiness
    do_clear();
    repeat (4) apply(2'b00, 2'b00, 2'b00, 2'b10);
    idle(1);
    check("settle_int0", elem_field(0), 4);
    check("settle_armed", {31'd0, armed}, 1);
    check("settle_viol", {28'd0, viol}, 0);
    apply(2'b00, 2'b00, 2'b00, 2'b10);
    idle(1);
    check("viol_set", {28'd0, viol}, 1);
    repeat (6) apply(2'b00, 2'b00, 2'b00, 2'b01);
    idle(1);
    check("viol_sticky", {28'd0, viol}, 1);

    // decimator: 16 x +15 with gaps
    do_clear();
    for (int i = 0; i < BLK; i++) begin
      apply(2'b10, 2'b10, 2'b10, 2'b10);
      idle(1);
    end
    step();
    check("dec_avg_240", $signed(y_avg), 240);
    check("dec_avg_vld", {31'd0, y_avg_vld}, 1);
    idle(1);
    check("dec_avg_pulse", {31'd0, y_avg_vld}, 0);

    // decimator: alternating +/-15
    for (int i = 0; i < BLK / 2; i++) begin
      apply(2'b10, 2'b10, 2'b10, 2'b10);
      apply(2'b01, 2'b01, 2'b01, 2'b01);
    end
    idle(2);
    check("alt_avg_0", $signed(y_avg), 0);
    check("alt_avg_vld", {31'd0, y_avg_vld}, 1);

    // clear coinciding with the 16th sample's y_vld
    do_clear();
    for (int i = 0; i < BLK; i++) apply(2'b00, 2'b10, 2'b00, 2'b00);
    idle(1);
    check("wrap_y_vld", {31'd0, y_vld}, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("wrap_no_pulse", {31'd0, y_avg_vld}, 0);
    check("wrap_int2", elem_field(2), 0);
    check("wrap_armed", {31'd0, armed}, 0);
    idle(2);
    check("wrap_no_late", {31'd0, y_avg_vld}, 0);
    for (int i = 0; i < BLK; i++) apply(2'b10, 2'b00, 2'b00, 2'b00);
    idle(2);
    check("fresh_avg_128", $signed(y_avg), 128);

    // saturation
    do_clear();
    repeat (IMAX + 9) apply(2'b10, 2'b00, 2'b00, 2'b00);
    idle(1);
    check("sat_int3", elem_field(3), IMAX);
    check("sat_viol3", {31'd0, viol[3]}, 1);

    // reset mid-block discards the partial sum
    for (int i = 0; i < 5; i++) apply(2'b10, 2'b10, 2'b00, 2'b00);
    do_reset();
    for (int i = 0; i < BLK; i++) apply(2'b00, 2'b00, 2'b10, 2'b00);
    idle(2);
    check("rst_avg_32", $signed(y_avg), 32);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      en    = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 4; k++) begin
        code_v[k] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      step();
      if (n % 997 == 500) do_reset();
    end
    en = 1'b0; clear = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ef_smsdac_dec_mon.md
# ef_smsdac_dec_mon

Receive-side decoder and monitor for the segmented mismatch-shaping DAC output bus. It registers the four 2-bit 3-level element codes (8x, 4x, 2x, 1x weights), decodes them to a signed weighted sample, and integrates each element's usage to check the mismatch-shaping boundedness property. It also produces a decimated block-sum of the decoded stream. It sits on the DAC output bus in test/bring-up builds and is transparent to the encoder path.

## Interface
- DEC_LOG2, 4, log2 of samples per decimated block (1..8)
- BOUND, 2, max allowed |per-element integrator| in RUN before violation
- INT_W, 6, per-element integrator width, signed, saturating
- SETTLE_N, 4, samples after reset/clear before violation checking arms (1..15)
- clk  in  1  sample clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- en  in  1  sample qualifier; codes accepted only when en=1
- clear  in  1  synchronous clear of integrators, flags, decimator, FSM
- code_3  in  2  8x-weight element code
- code_2  in  2  4x-weight element code
- code_1  in  2  2x-weight element code
- code_0  in  2  1x-weight element code
- y_sum  out  5  signed decoded sample, range -15..+15
- y_vld  out  1  y_sum valid strobe
- y_avg  out  5+DEC_LOG2  signed block sum of y_sum
- y_avg_vld  out  1  one-cycle pulse, y_avg updated
- elem_int  out  4*INT_W  packed integrators {int3,int2,int1,int0}
- viol  out  4  sticky per-element boundedness violation
- ill  out  4  sticky per-element illegal-code flag
- armed  out  1  FSM in RUN

## Operation
- Code map per element, {p,n}: 10 -> +1, 01 -> -1, 00 -> 0, 11 -> illegal, decoded as 0, sets ill[k].
- Stage 1: codes and en registered (s1_vld = en).
- Stage 2, when s1_vld: y_sum = 8*e3 + 4*e2 + 2*e1 + e0; y_vld = 1; int_k += e_k, saturating at ±(2^(INT_W-1)-1).
- Violation: in RUN, if post-update |int_k| > BOUND, set viol[k]; sticky until clear/reset.
- Decimator: on each y_vld, acc += y_sum and cnt++. On the sample where cnt wraps from 2^DEC_LOG2-1 to 0, y_avg = acc + y_sum, y_avg_vld = 1 next cycle, and acc restarts at 0. Width 5+DEC_LOG2 never overflows.
- FSM (counts stage-2 valid samples):
  - IDLE: goes to SETTLE on the first valid sample.
  - SETTLE: counts to SETTLE_N valid samples, then goes to RUN. The sample that completes the count is not checked.
  - RUN: violation checking is active.
- clear=1: integrators, acc, cnt, viol, ill -> 0; FSM -> IDLE; pipeline stages flushed (s1_vld, y_vld -> 0). y_sum and y_avg hold their values. clear has priority over en and over a sample in flight.
- en=0: no stage-1 valid. Integrators, decimator and FSM hold.

## Timing
- Reset values: y_sum=0, y_vld=0, y_avg=0, y_avg_vld=0, elem_int=0, viol=0, ill=0, armed=0, FSM=IDLE.
- Latency: code at edge N (en=1) -> y_sum/y_vld/elem_int updated after edge N+1.
- viol and ill assert in the same cycle as the causing y_vld.
- y_avg/y_avg_vld assert one cycle after the y_vld of the last sample in a block.
- y_vld and y_avg_vld are single-cycle unless the next sample is also valid.
- Simultaneous clear with wrap: clear wins, no y_avg_vld pulse.
- Saturation: an integrator at its limit holds. The violation check still applies.
- Asynchronous reset mid-block discards partial acc. The first block after release starts at cnt=0.

## Test plan
- Reset and idle: hold rst_b=0, then release with en=0 for 20 cycles -> all outputs 0, armed=0.
- Decode: apply codes {10,01,00,10}, en=1 for one cycle -> y_sum=+8-4+0+1=+5 two edges later, y_vld pulse, elem_int={1,-1,0,1}.
- Illegal code: code_2=11 with the others 00 -> y_sum=0, ill=4'b0100, viol unchanged.
- Settle/arm with defaults: four samples of code_0=10 -> int0=4, armed=1 after the fourth, viol=0. A fifth code_0=10 -> int0=5 > 2 -> viol[0]=1, sticky through later 01 codes.
- Decimator, DEC_LOG2=4: 16 samples of y_sum=+15 with gaps of en=0 -> single y_avg_vld with y_avg=240. 16 samples alternating ±15 -> y_avg=0.
- Clear at the wrap cycle: assert clear on the 16th sample's y_vld -> no y_avg_vld pulse, elem_int=0, armed=0. The next 16 samples produce a correct fresh block.
